// File: rtl/instr_fetch_cache.sv
// Instruction-fetch stage: direct-mapped one-word-per-line I-cache with a byte-serial
// refill from the memory controller and flush handling for ROB exceptions.
//   state  | meaning
//   IDLE   | look up pc_from_iq when the queue has room
//   BUBBLE | one idle cycle after an issue so the queue can advance its PC
//   MISS   | byte-by-byte refill of miss_pc
//   DRAIN  | flushed mid-request; wait out the outstanding byte and discard it
module instr_fetch_cache #(
    parameter int IDX_BITS = 6,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_from_iq,
    input  logic              iq_full,
    input  logic              is_exception,
    output logic              is_hit_to_iq,
    output logic [31:0]       instr_to_iq,
    output logic [ADDR_W-1:0] pc_to_iq,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_data
);

    localparam int LINES = 2 ** IDX_BITS;
    localparam int TAG_W = ADDR_W - IDX_BITS - 2;

    typedef enum logic [1:0] {IDLE, BUBBLE, MISS, DRAIN} state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [ADDR_W-1:0] miss_pc, miss_pc_next;
    logic [1:0]        cnt, cnt_next;
    logic [23:0]       bytes, bytes_next;

    logic              hit_next;
    logic [31:0]       instr_next;
    logic [ADDR_W-1:0] pc_out_next;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic              fill_en;
    logic [31:0]       fill_data;

    logic [IDX_BITS-1:0] look_idx, fill_idx;
    logic [TAG_W-1:0]    look_tag, fill_tag;
    logic                look_hit;
    logic [ADDR_W-1:0]   pc_aligned;

    assign look_idx   = pc_from_iq[IDX_BITS+1:2];
    assign look_tag   = pc_from_iq[ADDR_W-1:IDX_BITS+2];
    assign look_hit   = valid[look_idx] && (tag_mem[look_idx] == look_tag);
    assign pc_aligned = {pc_from_iq[ADDR_W-1:2], 2'b00};
    assign fill_idx   = miss_pc[IDX_BITS+1:2];
    assign fill_tag   = miss_pc[ADDR_W-1:IDX_BITS+2];
    assign fill_data  = {mem_data, bytes};

    always_comb begin
        state_next   = state;
        hit_next     = 1'b0;
        instr_next   = instr_to_iq;
        pc_out_next  = pc_to_iq;
        req_next     = mem_req;
        addr_next    = mem_addr;
        cnt_next     = cnt;
        miss_pc_next = miss_pc;
        bytes_next   = bytes;
        fill_en      = 1'b0;

        if (is_exception) begin
            // An outstanding byte must still be consumed so the controller sees its handshake close.
            cnt_next = 2'd0;
            if (mem_req && !mem_valid) begin
                state_next = DRAIN;
            end else begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!iq_full) begin
                        if (look_hit) begin
                            hit_next    = 1'b1;
                            instr_next  = data_mem[look_idx];
                            pc_out_next = pc_from_iq;
                            state_next  = BUBBLE;
                        end else begin
                            miss_pc_next = pc_aligned;
                            cnt_next     = 2'd0;
                            req_next     = 1'b1;
                            addr_next    = pc_aligned;
                            state_next   = MISS;
                        end
                    end
                end
                BUBBLE: state_next = IDLE;
                MISS: begin
                    if (mem_req) begin
                        if (mem_valid) begin
                            req_next = 1'b0;
                            cnt_next = cnt + 2'd1;
                            case (cnt)
                                2'd0:    bytes_next[7:0]   = mem_data;
                                2'd1:    bytes_next[15:8]  = mem_data;
                                2'd2:    bytes_next[23:16] = mem_data;
                                default: begin
                                    fill_en    = 1'b1;
                                    state_next = IDLE;
                                end
                            endcase
                        end
                    end else begin
                        req_next  = 1'b1;
                        addr_next = miss_pc + {{(ADDR_W-2){1'b0}}, cnt};
                    end
                end
                DRAIN: begin
                    if (mem_valid) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            is_hit_to_iq <= 1'b0;
            instr_to_iq  <= '0;
            pc_to_iq     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            cnt          <= 2'd0;
            miss_pc      <= '0;
            bytes        <= '0;
            valid        <= '0;
        end else begin
            state        <= state_next;
            is_hit_to_iq <= hit_next;
            instr_to_iq  <= instr_next;
            pc_to_iq     <= pc_out_next;
            mem_req      <= req_next;
            mem_addr     <= addr_next;
            cnt          <= cnt_next;
            miss_pc      <= miss_pc_next;
            bytes        <= bytes_next;
            if (fill_en) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_cache.sv
// Testbench for instr_fetch_cache: byte-memory responder plus a line-level cache model
// (which PC each index holds) that predicts hits, refill addresses and instruction words.
module tb_instr_fetch_cache;
    localparam int IDX_BITS = 6;
    localparam int ADDR_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] pc_from_iq = '0;
    logic              iq_full = 1'b1;
    logic              is_exception = 1'b0;
    logic              is_hit_to_iq;
    logic [31:0]       instr_to_iq;
    logic [ADDR_W-1:0] pc_to_iq;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid = 1'b0;
    logic [7:0]        mem_data = '0;

    int checks = 0;
    int errors = 0;
    bit auto_mem = 1'b0;
    logic [31:0] req_log[$];
    bit          model_valid[64];
    logic [31:0] model_pc[64];

    instr_fetch_cache #(.IDX_BITS(IDX_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .pc_from_iq(pc_from_iq), .iq_full(iq_full),
        .is_exception(is_exception), .is_hit_to_iq(is_hit_to_iq), .instr_to_iq(instr_to_iq),
        .pc_to_iq(pc_to_iq), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endfunction

    // Automatic memory controller: random 0..2 cycle latency, one-cycle valid pulse.
    initial begin
        int dly;
        forever begin
            @(negedge clk);
            if (auto_mem) mem_valid = 1'b0;
            if (auto_mem && mem_req && !rst) begin
                dly = $urandom_range(0, 2);
                repeat (dly) @(negedge clk);
                if (auto_mem && mem_req && !rst) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_byte(mem_addr);
                    req_log.push_back(mem_addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Request one PC and follow it until it issues; checks against the line-level model.
    task automatic fetch_check(input logic [31:0] pc, input string name);
        bit exp_hit;
        bit seen;
        int n;
        logic [5:0] idx;
        idx = pc[7:2];
        exp_hit = model_valid[idx] && (model_pc[idx] == pc);
        @(negedge clk);
        req_log.delete();
        pc_from_iq = pc;
        iq_full    = 1'b0;
        auto_mem   = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (is_hit_to_iq) seen = 1'b1;
        end
        iq_full = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s issue_timeout: no hit after %0d cycles, pc 0x%08h", name, n, pc);
        end else begin
            checks++;
            if (instr_to_iq !== mem_word(pc)) begin
                errors++;
                $display("FAIL %s instr: got 0x%08h expected 0x%08h", name, instr_to_iq, mem_word(pc));
            end
            checks++;
            if (pc_to_iq !== pc) begin
                errors++;
                $display("FAIL %s pc: got 0x%08h expected 0x%08h", name, pc_to_iq, pc);
            end
            if (exp_hit) begin
                checks++;
                if (n != 1) begin
                    errors++;
                    $display("FAIL %s hit_latency: got %0d cycles expected 1", name, n);
                end
                checks++;
                if (req_log.size() != 0) begin
                    errors++;
                    $display("FAIL %s hit_mem_reqs: got %0d requests expected 0", name, req_log.size());
                end
            end else begin
                checks++;
                if (req_log.size() != 4) begin
                    errors++;
                    $display("FAIL %s miss_mem_reqs: got %0d requests expected 4", name, req_log.size());
                end
                for (int i = 0; i < req_log.size() && i < 4; i++) begin
                    checks++;
                    if (req_log[i] !== pc + i) begin
                        errors++;
                        $display("FAIL %s req_addr[%0d]: got 0x%08h expected 0x%08h", name, i, req_log[i], pc + i);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (is_hit_to_iq !== 1'b0) begin
            errors++;
            $display("FAIL %s hit_pulse_width: hit still %b one cycle later, expected 0", name, is_hit_to_iq);
        end
        model_valid[idx] = 1'b1;
        model_pc[idx]    = pc;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL %s req_timeout: mem_req %b expected 1", name, mem_req);
        end
    endtask

    task automatic serve_byte(input logic [31:0] exp_addr, input string name);
        checks++;
        if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s mem_addr: got 0x%08h expected 0x%08h", name, mem_addr, exp_addr);
        end
        mem_valid = 1'b1;
        mem_data  = mem_byte(mem_addr);
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        auto_mem = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({is_hit_to_iq, instr_to_iq, pc_to_iq, mem_req, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: hit=%b instr=0x%08h pc=0x%08h req=%b addr=0x%08h expected all 0",
                     is_hit_to_iq, instr_to_iq, pc_to_iq, mem_req, mem_addr);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if ({is_hit_to_iq, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: hit=%b req=%b expected 0 0", is_hit_to_iq, mem_req);
        end
        fetch_check(32'h0, "reset_first_miss");
    endtask

    task automatic test_cold_miss();
        fetch_check(32'h100, "cold_miss");
        checks++;
        if (instr_to_iq !== 32'h00100513) begin
            errors++;
            $display("FAIL cold_miss_word: got 0x%08h expected 0x00100513", instr_to_iq);
        end
        fetch_check(32'h100, "cold_refetch_hit");
    endtask

    task automatic test_hit_stream();
        int hits;
        fetch_check(32'h104, "stream_fill1");
        fetch_check(32'h108, "stream_fill2");
        fetch_check(32'h10C, "stream_fill3");
        @(negedge clk);
        pc_from_iq = 32'h100;
        iq_full    = 1'b0;
        hits = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (is_hit_to_iq) begin
                checks++;
                if (cyc != 2 * hits + 1) begin
                    errors++;
                    $display("FAIL stream_spacing: hit %0d at cycle %0d expected cycle %0d", hits, cyc, 2 * hits + 1);
                end
                checks++;
                if (pc_to_iq !== 32'h100 + 4 * hits) begin
                    errors++;
                    $display("FAIL stream_pc: got 0x%08h expected 0x%08h", pc_to_iq, 32'h100 + 4 * hits);
                end
                checks++;
                if (instr_to_iq !== mem_word(32'h100 + 4 * hits)) begin
                    errors++;
                    $display("FAIL stream_instr: got 0x%08h expected 0x%08h", instr_to_iq, mem_word(32'h100 + 4 * hits));
                end
                hits++;
                pc_from_iq = pc_from_iq + 4;
                if (hits == 4) iq_full = 1'b1;
            end
        end
        checks++;
        if (hits != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d hits expected 4", hits);
        end
    endtask

    task automatic test_full();
        @(negedge clk);
        pc_from_iq = 32'h104;
        iq_full    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (is_hit_to_iq !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL full_stall[%0d]: hit=%b req=%b expected 0 0", i, is_hit_to_iq, mem_req);
            end
        end
        iq_full = 1'b0;
        @(negedge clk);
        iq_full = 1'b1;
        checks++;
        if (is_hit_to_iq !== 1'b1 || pc_to_iq !== 32'h104) begin
            errors++;
            $display("FAIL full_release: hit=%b pc=0x%08h expected 1 0x00000104", is_hit_to_iq, pc_to_iq);
        end
        @(negedge clk);
        checks++;
        if (is_hit_to_iq !== 1'b0) begin
            errors++;
            $display("FAIL full_release_pulse: hit=%b expected 0", is_hit_to_iq);
        end
    endtask

    task automatic test_flush();
        auto_mem = 1'b0;
        @(negedge clk);
        pc_from_iq = 32'h200;
        iq_full    = 1'b0;
        wait_req("flush_b0");
        iq_full = 1'b1;
        serve_byte(32'h200, "flush_b0");
        wait_req("flush_b1");
        serve_byte(32'h201, "flush_b1");
        wait_req("flush_b2");
        checks++;
        if (mem_addr !== 32'h202) begin
            errors++;
            $display("FAIL flush_b2_addr: got 0x%08h expected 0x00000202", mem_addr);
        end
        is_exception = 1'b1;
        @(negedge clk);
        is_exception = 1'b0;
        pc_from_iq   = 32'h80;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h202 || is_hit_to_iq !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_enter: req=%b addr=0x%08h hit=%b expected 1 0x00000202 0",
                     mem_req, mem_addr, is_hit_to_iq);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h202) begin
            errors++;
            $display("FAIL flush_drain_hold: req=%b addr=0x%08h expected 1 0x00000202", mem_req, mem_addr);
        end
        mem_valid = 1'b1;
        mem_data  = 8'hFF;
        @(negedge clk);
        mem_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_exit: req=%b expected 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || is_hit_to_iq !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: req=%b hit=%b expected 0 0", mem_req, is_hit_to_iq);
        end
        fetch_check(32'h80, "flush_redirect");
        fetch_check(32'h200, "flush_line_invalid");
    endtask

    task automatic test_valid_with_exception();
        auto_mem = 1'b0;
        @(negedge clk);
        pc_from_iq = 32'h300;
        iq_full    = 1'b0;
        wait_req("vex_b0");
        iq_full = 1'b1;
        serve_byte(32'h300, "vex_b0");
        wait_req("vex_b1");
        mem_valid    = 1'b1;
        mem_data     = mem_byte(mem_addr);
        is_exception = 1'b1;
        @(negedge clk);
        mem_valid    = 1'b0;
        is_exception = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL vex_req_drop: req=%b expected 0", mem_req);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || is_hit_to_iq !== 1'b0) begin
            errors++;
            $display("FAIL vex_idle: req=%b hit=%b expected 0 0", mem_req, is_hit_to_iq);
        end
        fetch_check(32'h300, "vex_refetch");
    endtask

    task automatic test_reset_midrefill();
        auto_mem = 1'b0;
        @(negedge clk);
        pc_from_iq = 32'h400;
        iq_full    = 1'b0;
        wait_req("rmid_b0");
        iq_full = 1'b1;
        serve_byte(32'h400, "rmid_b0");
        wait_req("rmid_b1");
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rmid_async: req=%b addr=0x%08h expected 0 0", mem_req, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        fetch_check(32'h104, "rmid_after_reset");
    endtask

    task automatic test_alias();
        fetch_check(32'h000, "alias_a");
        fetch_check(32'h100, "alias_b");
        fetch_check(32'h000, "alias_a_again");
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int i = 0; i < 40; i++) begin
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            fetch_check(pc, "random");
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_full();
        test_flush();
        test_valid_with_exception();
        test_reset_midrefill();
        test_alias();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
